// File: rtl/lock_pkg.sv
// Shared types and sizes for the lock front-end: symbol width, slot counts
// and the entry-progress states derived from the held-symbol count.
package lock_pkg;

    localparam int SYM_W        = 5;
    localparam int NUM_USER_SYM = 4;
    localparam int NUM_PASS_SYM = 4;
    localparam int ENTRY_LEN    = NUM_USER_SYM + NUM_PASS_SYM;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        USER  = 2'd1,
        PASS  = 2'd2,
        FULL  = 2'd3
    } entry_state_t;

    // Entry progress is a pure function of how many symbols are held.
    function automatic entry_state_t state_of(input logic [3:0] cnt);
        if (cnt == 4'd0)
            return EMPTY;
        else if (cnt < 4'(NUM_USER_SYM))
            return USER;
        else if (cnt < 4'(ENTRY_LEN))
            return PASS;
        else
            return FULL;
    endfunction

endpackage

// File: rtl/credential_entry_if.sv
// Keypad-to-unlocker bundle: keypad strobes in, username/password slots,
// count and status out, plus the derived entry state for observation.
interface credential_entry_if;
    import lock_pkg::*;

    // Handshake: sym_valid, bksp, clear and locker are single-cycle strobes
    // with no ready; the entry stage consumes every strobe on the edge it is
    // high, resolving same-cycle strobes by priority (locker/clear > bksp >
    // sym_valid) and dropping the losers. sym is only meaningful with sym_valid.
    logic         sym_valid;
    sym_t         sym;
    logic         bksp;
    logic         clear;
    logic         locker;

    sym_t         userNameInput0;
    sym_t         userNameInput1;
    sym_t         userNameInput2;
    sym_t         userNameInput3;
    sym_t         passwordInput0;
    sym_t         passwordInput1;
    sym_t         passwordInput2;
    sym_t         passwordInput3;
    logic [3:0]   inputCount;
    logic         entry_full;
    logic         wiped;
    entry_state_t state;

    modport master (
        output sym_valid, sym, bksp, clear, locker,
        input  userNameInput0, userNameInput1, userNameInput2, userNameInput3,
        input  passwordInput0, passwordInput1, passwordInput2, passwordInput3,
        input  inputCount, entry_full, wiped, state
    );

    modport slave (
        input  sym_valid, sym, bksp, clear, locker,
        output userNameInput0, userNameInput1, userNameInput2, userNameInput3,
        output passwordInput0, passwordInput1, passwordInput2, passwordInput3,
        output inputCount, entry_full, wiped, state
    );

endinterface

// File: rtl/idle_timer.sv
// Inactivity timer with two selectable limits; expire is a combinational
// pulse on the cycle the count reaches limit-1, and the count then restarts.
module idle_timer #(
    parameter int CNT_W   = 26,
    parameter int LIMIT_A = 50_000_000,
    parameter int LIMIT_B = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sel_b,
    output logic expire
);

    logic [CNT_W-1:0] t_q;
    logic [CNT_W-1:0] lim_m1;

    assign lim_m1 = sel_b ? CNT_W'(LIMIT_B - 1) : CNT_W'(LIMIT_A - 1);
    assign expire = en && !clr && (t_q == lim_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            t_q <= '0;
        else if (clr || expire)
            t_q <= '0;
        else if (en)
            t_q <= t_q + CNT_W'(1);
    end

endmodule

// File: rtl/credential_entry.sv
// Keypad entry stage: gathers a 4-symbol username then a 4-symbol password,
// with backspace, clear/lock wipe, and auto-wipe on idle or after a full hold.
module credential_entry
    import lock_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 50_000_000,
    parameter int FULL_HOLD    = 4,
    parameter int CNT_W        = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    credential_entry_if.slave  ent
);

    sym_t [0:ENTRY_LEN-1] slots_q, slots_d;
    logic [3:0]           count_q, count_d;
    logic                 wiped_q, wiped_d;
    logic                 full_q;
    entry_state_t         state;
    logic                 do_clr, do_bksp, do_sym;
    logic                 tmr_clr, tmr_en, expire;
    logic [2:0]           del_idx;

    assign state   = state_of(count_q);
    assign del_idx = count_q[2:0] - 3'd1;

    // A bksp strobe wins over sym_valid even at count 0, where it does nothing.
    assign do_clr  = ent.locker || ent.clear;
    assign do_bksp = !do_clr && ent.bksp && (count_q != 4'd0);
    assign do_sym  = !do_clr && !ent.bksp && ent.sym_valid
                     && (count_q < 4'(ENTRY_LEN));

    // Any accepted edit restarts the timer; EMPTY keeps it parked at zero.
    assign tmr_clr = do_clr || do_bksp || do_sym || (state == EMPTY);
    assign tmr_en  = (state != EMPTY);

    idle_timer #(
        .CNT_W   (CNT_W),
        .LIMIT_A (IDLE_TIMEOUT),
        .LIMIT_B (FULL_HOLD)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .sel_b  (state == FULL),
        .expire (expire)
    );

    always_comb begin
        slots_d = slots_q;
        count_d = count_q;
        wiped_d = 1'b0;
        if (do_clr) begin
            slots_d = '0;
            count_d = 4'd0;
        end else if (do_bksp) begin
            slots_d[del_idx] = '0;
            count_d          = count_q - 4'd1;
        end else if (do_sym) begin
            slots_d[count_q[2:0]] = ent.sym;
            count_d               = count_q + 4'd1;
        end else if (expire) begin
            slots_d = '0;
            count_d = 4'd0;
            wiped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
            count_q <= 4'd0;
            wiped_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            slots_q <= slots_d;
            count_q <= count_d;
            wiped_q <= wiped_d;
            full_q  <= (count_d == 4'(ENTRY_LEN));
        end
    end

    assign ent.userNameInput0 = slots_q[0];
    assign ent.userNameInput1 = slots_q[1];
    assign ent.userNameInput2 = slots_q[2];
    assign ent.userNameInput3 = slots_q[3];
    assign ent.passwordInput0 = slots_q[4];
    assign ent.passwordInput1 = slots_q[5];
    assign ent.passwordInput2 = slots_q[6];
    assign ent.passwordInput3 = slots_q[7];
    assign ent.inputCount     = count_q;
    assign ent.entry_full     = full_q;
    assign ent.wiped          = wiped_q;
    assign ent.state          = state;

endmodule

// File: tb/tb_credential_entry.sv
// Directed bench for credential_entry: a vector table for entry, backspace,
// clear and full-hold behaviour, then hand sequences for idle and reset cases.
module tb_credential_entry;
    import lock_pkg::*;

    localparam logic [4:0] Z = 5'd0;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    credential_entry_if ifc();

    credential_entry #(
        .IDLE_TIMEOUT (20),
        .FULL_HOLD    (4),
        .CNT_W        (26)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ent   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sv;
        logic [4:0]  sym;
        logic        bk;
        logic        cl;
        logic        lk;
        logic [3:0]  cnt;
        logic        full;
        logic        wp;
        logic [39:0] slots;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic sv, input logic [4:0] sym,
                                input logic bk, input logic cl, input logic lk,
                                input logic [3:0] cnt, input logic full,
                                input logic wp, input logic [39:0] slots);
        return vec_t'({sv, sym, bk, cl, lk, cnt, full, wp, slots});
    endfunction

    // Appends n consecutive symbol entries 1..n starting from an empty entry.
    task automatic push_fill(input int n);
        logic [39:0] s;
        s = '0;
        for (int k = 1; k <= n; k++) begin
            s[39-5*(k-1) -: 5] = 5'(k);
            tbl.push_back(mk(1'b1, 5'(k), 1'b0, 1'b0, 1'b0, 4'(k), (k == 8), 1'b0, s));
        end
    endtask

    function automatic logic [39:0] dut_slots();
        return {ifc.userNameInput0, ifc.userNameInput1, ifc.userNameInput2, ifc.userNameInput3,
                ifc.passwordInput0, ifc.passwordInput1, ifc.passwordInput2, ifc.passwordInput3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic sv, input logic [4:0] sym,
                         input logic bk, input logic cl, input logic lk);
        ifc.sym_valid = sv;
        ifc.sym       = sym;
        ifc.bksp      = bk;
        ifc.clear     = cl;
        ifc.locker    = lk;
        @(posedge clk);
        #1;
        ifc.sym_valid = 1'b0;
        ifc.sym       = 5'd0;
        ifc.bksp      = 1'b0;
        ifc.clear     = 1'b0;
        ifc.locker    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            apply(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sym_in(input logic [4:0] s);
        apply(1'b1, s, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        ifc.sym_valid = 1'b0;
        ifc.sym       = 5'd0;
        ifc.bksp      = 1'b0;
        ifc.clear     = 1'b0;
        ifc.locker    = 1'b0;

        // full entry on spaced cycles, ignored ninth symbol, FULL_HOLD auto-wipe
        tbl.push_back(mk(1, 5'd1,  0, 0, 0, 4'd1, 0, 0, {5'd1, Z, Z, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd1, 0, 0, {5'd1, Z, Z, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd2,  0, 0, 0, 4'd2, 0, 0, {5'd1, 5'd2, Z, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd2, 0, 0, {5'd1, 5'd2, Z, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd3,  0, 0, 0, 4'd3, 0, 0, {5'd1, 5'd2, 5'd3, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd3, 0, 0, {5'd1, 5'd2, 5'd3, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd4,  0, 0, 0, 4'd4, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, Z, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd4, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, Z, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd5,  0, 0, 0, 4'd5, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd5, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd6,  0, 0, 0, 4'd6, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd6, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, Z, Z}));
        tbl.push_back(mk(1, 5'd7,  0, 0, 0, 4'd7, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd7, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, Z}));
        tbl.push_back(mk(1, 5'd8,  0, 0, 0, 4'd8, 1, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}));
        tbl.push_back(mk(1, 5'd31, 0, 0, 0, 4'd8, 1, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd8, 1, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd8, 1, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd0, 0, 1, 40'd0));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd0, 0, 0, 40'd0));
        // backspace at zero, edit within the username, then clear
        tbl.push_back(mk(0, 5'd0,  1, 0, 0, 4'd0, 0, 0, 40'd0));
        tbl.push_back(mk(1, 5'd9,  0, 0, 0, 4'd1, 0, 0, {5'd9, Z, Z, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd10, 0, 0, 0, 4'd2, 0, 0, {5'd9, 5'd10, Z, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd11, 0, 0, 0, 4'd3, 0, 0, {5'd9, 5'd10, 5'd11, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  1, 0, 0, 4'd2, 0, 0, {5'd9, 5'd10, Z, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(1, 5'd12, 0, 0, 0, 4'd3, 0, 0, {5'd9, 5'd10, 5'd12, Z, Z, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 1, 0, 4'd0, 0, 0, 40'd0));
        // simultaneous strobes at count 6
        push_fill(6);
        tbl.push_back(mk(1, 5'd7,  1, 1, 0, 4'd0, 0, 0, 40'd0));
        push_fill(6);
        tbl.push_back(mk(1, 5'd20, 1, 0, 0, 4'd5, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, Z, Z, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 1, 4'd0, 0, 0, 40'd0));
        // backspace out of FULL lands in PASS at count 7
        push_fill(8);
        tbl.push_back(mk(0, 5'd0,  1, 0, 0, 4'd7, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 0, 4'd7, 0, 0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, Z}));
        tbl.push_back(mk(0, 5'd0,  0, 0, 1, 4'd0, 0, 0, 40'd0));

        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset cnt",   64'(ifc.inputCount), 64'd0);
        check("reset full",  64'(ifc.entry_full), 64'd0);
        check("reset wiped", 64'(ifc.wiped), 64'd0);
        check("reset slots", 64'(dut_slots()), 64'd0);
        check("reset state", 64'(ifc.state), 64'(EMPTY));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].sv, tbl[i].sym, tbl[i].bk, tbl[i].cl, tbl[i].lk);
            check($sformatf("vec%0d cnt", i),   64'(ifc.inputCount), 64'(tbl[i].cnt));
            check($sformatf("vec%0d full", i),  64'(ifc.entry_full), 64'(tbl[i].full));
            check($sformatf("vec%0d wiped", i), 64'(ifc.wiped), 64'(tbl[i].wp));
            check($sformatf("vec%0d slots", i), 64'(dut_slots()), 64'(tbl[i].slots));
        end

        // idle timeout: 5 symbols, wipe lands on the 20th idle cycle
        for (int k = 1; k <= 5; k++)
            sym_in(5'(k));
        idle(19);
        check("idle19 cnt",   64'(ifc.inputCount), 64'd5);
        check("idle19 wiped", 64'(ifc.wiped), 64'd0);
        idle(1);
        check("idle20 cnt",   64'(ifc.inputCount), 64'd0);
        check("idle20 wiped", 64'(ifc.wiped), 64'd1);
        check("idle20 slots", 64'(dut_slots()), 64'd0);
        idle(1);
        check("idle21 wiped", 64'(ifc.wiped), 64'd0);

        // a symbol on idle cycle 19 restarts the timer
        for (int k = 1; k <= 5; k++)
            sym_in(5'(k));
        idle(18);
        sym_in(5'd6);
        idle(1);
        check("rescue cnt",   64'(ifc.inputCount), 64'd6);
        check("rescue wiped", 64'(ifc.wiped), 64'd0);
        check("rescue slots", 64'(dut_slots()),
              64'({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, Z, Z}));
        check("rescue state", 64'(ifc.state), 64'(PASS));
        apply(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rescue clear", 64'(ifc.inputCount), 64'd0);

        // asynchronous reset mid-cycle at count 7
        for (int k = 1; k <= 7; k++)
            sym_in(5'(k));
        check("pre-rst cnt", 64'(ifc.inputCount), 64'd7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async cnt",   64'(ifc.inputCount), 64'd0);
        check("async slots", 64'(dut_slots()), 64'd0);
        check("async state", 64'(ifc.state), 64'(EMPTY));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("post-rst cnt", 64'(ifc.inputCount), 64'd0);
        sym_in(5'd3);
        check("restart cnt",   64'(ifc.inputCount), 64'd1);
        check("restart slots", 64'(dut_slots()), 64'({5'd3, Z, Z, Z, Z, Z, Z, Z}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
